// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths, field-offset helpers and the decoded record for decoder_pipe.
package decoder_pkg;
    localparam int OPCODE_WIDTH_DEF  = 4;
    localparam int REG_SEL_WIDTH_DEF = 3;
    localparam int IMM_WIDTH_DEF     = 8;
    localparam int INSTR_WIDTH_DEF   = 16;
    localparam int DATA_WIDTH_DEF    = 16;
    // The record is sized for the widest supported configuration; narrower ones zero-pad.
    localparam int OPCODE_WIDTH_MAX  = 8;
    localparam int REG_SEL_WIDTH_MAX = 8;
    localparam int DATA_WIDTH_MAX    = 64;

    typedef struct packed {
        logic [OPCODE_WIDTH_MAX-1:0]  opcode;
        logic [REG_SEL_WIDTH_MAX-1:0] rd_sel;
        logic [REG_SEL_WIDTH_MAX-1:0] ra_sel;
        logic [REG_SEL_WIDTH_MAX-1:0] rb_sel;
        logic                         flag;
        logic [DATA_WIDTH_MAX-1:0]    imm;
        logic                         writes_rd;
    } decoded_t;

    function automatic int rd_lsb(input int instr_w, input int opc_w, input int sel_w);
        return instr_w - opc_w - sel_w;
    endfunction

    function automatic int flag_pos(input int instr_w, input int opc_w, input int sel_w);
        return instr_w - opc_w - sel_w - 1;
    endfunction

    function automatic int ra_lsb(input int imm_w, input int sel_w);
        return imm_w - sel_w;
    endfunction

    function automatic int rb_lsb(input int imm_w, input int sel_w);
        return imm_w - 2 * sel_w;
    endfunction
endpackage

// File: rtl/decoder_fields.sv
// decoder_fields: combinational split of an instruction word into a decoded_t record.
module decoder_fields
    import decoder_pkg::*;
#(
    parameter int OPCODE_WIDTH  = OPCODE_WIDTH_DEF,
    parameter int REG_SEL_WIDTH = REG_SEL_WIDTH_DEF,
    parameter int IMM_WIDTH     = IMM_WIDTH_DEF,
    parameter int INSTR_WIDTH   = INSTR_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter logic [(1<<OPCODE_WIDTH)-1:0] SIGNED_IMM_MASK = '0,
    parameter logic [(1<<OPCODE_WIDTH)-1:0] WRITES_RD_MASK  = '1
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    output decoded_t               dec_o
);
    localparam int RD_LSB   = rd_lsb(INSTR_WIDTH, OPCODE_WIDTH, REG_SEL_WIDTH);
    localparam int FLAG_POS = flag_pos(INSTR_WIDTH, OPCODE_WIDTH, REG_SEL_WIDTH);
    localparam int RA_LSB   = ra_lsb(IMM_WIDTH, REG_SEL_WIDTH);
    localparam int RB_LSB   = rb_lsb(IMM_WIDTH, REG_SEL_WIDTH);

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [IMM_WIDTH-1:0]    imm_raw;
    logic                    neg;
    logic [DATA_WIDTH-1:0]   imm_ext;

    assign opcode  = instr_i[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign imm_raw = instr_i[IMM_WIDTH-1:0];
    assign neg     = SIGNED_IMM_MASK[opcode] & imm_raw[IMM_WIDTH-1];
    // Ones shifted above the raw field; vanishes when DATA_WIDTH == IMM_WIDTH.
    assign imm_ext = DATA_WIDTH'(imm_raw) | ({DATA_WIDTH{neg}} << IMM_WIDTH);

    always_comb begin
        dec_o           = '0;
        dec_o.opcode    = OPCODE_WIDTH_MAX'(opcode);
        dec_o.rd_sel    = REG_SEL_WIDTH_MAX'(instr_i[RD_LSB +: REG_SEL_WIDTH]);
        dec_o.ra_sel    = REG_SEL_WIDTH_MAX'(instr_i[RA_LSB +: REG_SEL_WIDTH]);
        dec_o.rb_sel    = REG_SEL_WIDTH_MAX'(instr_i[RB_LSB +: REG_SEL_WIDTH]);
        dec_o.flag      = instr_i[FLAG_POS];
        dec_o.imm       = DATA_WIDTH_MAX'(imm_ext);
        dec_o.writes_rd = WRITES_RD_MASK[opcode];
    end
endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: flow-controlled instruction decoder with an output register and a one-deep skid buffer.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int OPCODE_WIDTH  = OPCODE_WIDTH_DEF,
    parameter int REG_SEL_WIDTH = REG_SEL_WIDTH_DEF,
    parameter int IMM_WIDTH     = IMM_WIDTH_DEF,
    parameter int INSTR_WIDTH   = INSTR_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter logic [(1<<OPCODE_WIDTH)-1:0] SIGNED_IMM_MASK = '0,
    parameter logic [(1<<OPCODE_WIDTH)-1:0] WRITES_RD_MASK  = '1
) (
    input  logic                     I_clk,
    input  logic                     I_reset,
    input  logic                     I_enable,
    input  logic                     I_flush,
    input  logic                     I_valid,
    output logic                     O_ready,
    input  logic [INSTR_WIDTH-1:0]   I_instruction,
    output logic                     O_valid,
    input  logic                     I_ready,
    output logic [OPCODE_WIDTH-1:0]  O_opcode,
    output logic [REG_SEL_WIDTH-1:0] O_rD_select,
    output logic [REG_SEL_WIDTH-1:0] O_rA_select,
    output logic [REG_SEL_WIDTH-1:0] O_rB_select,
    output logic                     O_flag,
    output logic [DATA_WIDTH-1:0]    O_immediate,
    output logic                     O_writes_rd
);
    decoded_t in_dec;
    decoded_t out_q, out_d, skid_q, skid_d;
    logic     out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic     accept, out_free;
    logic     unused_bits;

    decoder_fields #(
        .OPCODE_WIDTH   (OPCODE_WIDTH),
        .REG_SEL_WIDTH  (REG_SEL_WIDTH),
        .IMM_WIDTH      (IMM_WIDTH),
        .INSTR_WIDTH    (INSTR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .SIGNED_IMM_MASK(SIGNED_IMM_MASK),
        .WRITES_RD_MASK (WRITES_RD_MASK)
    ) u_fields (
        .instr_i(I_instruction),
        .dec_o  (in_dec)
    );

    // Ready depends only on registered state, never on I_ready.
    assign O_ready  = I_enable & ~skid_valid_q & ~I_reset;
    assign accept   = I_valid & O_ready;
    assign out_free = ~out_valid_q | I_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (I_enable) begin
            if (I_flush) begin
                out_valid_d  = 1'b0;
                skid_valid_d = 1'b0;
            end else if (out_free) begin
                out_d        = skid_valid_q ? skid_q : in_dec;
                out_valid_d  = skid_valid_q | accept;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                skid_d       = in_dec;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign O_valid     = out_valid_q;
    assign O_opcode    = out_q.opcode[OPCODE_WIDTH-1:0];
    assign O_rD_select = out_q.rd_sel[REG_SEL_WIDTH-1:0];
    assign O_rA_select = out_q.ra_sel[REG_SEL_WIDTH-1:0];
    assign O_rB_select = out_q.rb_sel[REG_SEL_WIDTH-1:0];
    assign O_flag      = out_q.flag;
    assign O_immediate = out_q.imm[DATA_WIDTH-1:0];
    assign O_writes_rd = out_q.writes_rd;
    // Padding bits of the wide record are always zero.
    assign unused_bits = ^out_q;
endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed and random checks of decoder_pipe against a queue-based reference model.
module tb_decoder_pipe;
    localparam int SMASK = 'h0004;
    localparam int WMASK = 'hBFFE;

    logic        I_clk, I_reset, I_enable, I_flush, I_valid, I_ready;
    logic [15:0] I_instruction;
    logic        O_ready, O_valid, O_flag, O_writes_rd;
    logic [3:0]  O_opcode;
    logic [2:0]  O_rD_select, O_rA_select, O_rB_select;
    logic [15:0] O_immediate;
    logic        z_ready, z_valid, z_flag, z_writes_rd;
    logic [3:0]  z_opcode;
    logic [2:0]  z_rd, z_ra, z_rb;
    logic [15:0] z_imm;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] q[$];

    decoder_pipe #(.SIGNED_IMM_MASK(16'h0004), .WRITES_RD_MASK(16'hBFFE)) dut (
        .I_clk(I_clk), .I_reset(I_reset), .I_enable(I_enable), .I_flush(I_flush),
        .I_valid(I_valid), .O_ready(O_ready), .I_instruction(I_instruction),
        .O_valid(O_valid), .I_ready(I_ready), .O_opcode(O_opcode),
        .O_rD_select(O_rD_select), .O_rA_select(O_rA_select), .O_rB_select(O_rB_select),
        .O_flag(O_flag), .O_immediate(O_immediate), .O_writes_rd(O_writes_rd)
    );

    decoder_pipe #(.SIGNED_IMM_MASK(16'h0000), .WRITES_RD_MASK(16'hBFFE)) dut_z (
        .I_clk(I_clk), .I_reset(I_reset), .I_enable(I_enable), .I_flush(I_flush),
        .I_valid(I_valid), .O_ready(z_ready), .I_instruction(I_instruction),
        .O_valid(z_valid), .I_ready(I_ready), .O_opcode(z_opcode),
        .O_rD_select(z_rd), .O_rA_select(z_ra), .O_rB_select(z_rb),
        .O_flag(z_flag), .O_immediate(z_imm), .O_writes_rd(z_writes_rd)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected decode computed directly from the field layout with shifts and masks.
    task automatic check_fields(input logic [15:0] w);
        int op, raw, imm;
        op  = int'(w) >> 12;
        raw = int'(w) & 255;
        imm = (((SMASK >> op) & 1) == 1 && raw >= 128) ? raw + 'hFF00 : raw;
        chk("opcode", 32'(O_opcode), op);
        chk("rd", 32'(O_rD_select), (int'(w) >> 9) & 7);
        chk("flag", 32'(O_flag), (int'(w) >> 8) & 1);
        chk("ra", 32'(O_rA_select), (int'(w) >> 5) & 7);
        chk("rb", 32'(O_rB_select), (int'(w) >> 2) & 7);
        chk("imm", 32'(O_immediate), imm);
        chk("writes_rd", 32'(O_writes_rd), (WMASK >> op) & 1);
    endtask

    task automatic check_zero();
        chk("rst_valid", 32'(O_valid), 0);
        chk("rst_opcode", 32'(O_opcode), 0);
        chk("rst_rd", 32'(O_rD_select), 0);
        chk("rst_ra", 32'(O_rA_select), 0);
        chk("rst_rb", 32'(O_rB_select), 0);
        chk("rst_flag", 32'(O_flag), 0);
        chk("rst_imm", 32'(O_immediate), 0);
        chk("rst_writes_rd", 32'(O_writes_rd), 0);
    endtask

    // One cycle: drive at negedge, check at negedge+1, update the model, wait for the next negedge.
    task automatic step(input bit v, input logic [15:0] w, input bit r);
        bit acc, emit;
        I_valid = v;
        I_instruction = w;
        I_ready = r;
        #1;
        chk("o_ready", 32'(O_ready), I_enable ? 32'(q.size() < 2) : 0);
        chk("o_valid", 32'(O_valid), 32'(q.size() > 0));
        if (O_valid && q.size() > 0) check_fields(q[0]);
        acc  = v && I_enable && !I_flush && q.size() < 2;
        emit = r && I_enable && !I_flush && q.size() > 0;
        if (I_enable && I_flush) q.delete();
        if (emit) void'(q.pop_front());
        if (acc) q.push_back(w);
        @(negedge I_clk);
    endtask

    initial begin
        int acc_cnt;
        I_reset = 1'b1; I_enable = 1'b1; I_flush = 1'b0;
        I_valid = 1'b1; I_ready = 1'b1; I_instruction = 16'h1A3C;
        @(negedge I_clk);
        @(negedge I_clk);
        #1;
        chk("rst_ready", 32'(O_ready), 0);
        check_zero();
        I_reset = 1'b0;

        step(1, 16'h1A3C, 1);
        #1;
        chk("t1_opcode", 32'(O_opcode), 1);
        chk("t1_ra", 32'(O_rA_select), 1);
        chk("t1_rb", 32'(O_rB_select), 7);
        chk("t1_imm", 32'(O_immediate), 'h003C);
        step(1, 16'h25F0, 1);
        #1;
        chk("t2_imm_signed", 32'(O_immediate), 'hFFF0);
        chk("t2_imm_zero", 32'(z_imm), 'h00F0);
        chk("t2_rb", 32'(O_rB_select), 4);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);

        // Skid: second word captured while the first is stalled for three cycles.
        step(1, 16'h1A3C, 1);
        step(1, 16'h25F0, 0);
        step(1, 16'hDEAD, 0);
        step(1, 16'hBEEF, 0);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);

        // Flush with OUT and SKID full plus a valid input.
        step(1, 16'h3111, 0);
        step(1, 16'h4222, 0);
        I_flush = 1'b1;
        step(1, 16'h5333, 1);
        I_flush = 1'b0;
        step(0, 16'h0000, 1);
        // Flush with only OUT full: input dropped although ready was high.
        step(1, 16'h6444, 0);
        I_flush = 1'b1;
        step(1, 16'h7555, 0);
        I_flush = 1'b0;
        step(0, 16'h0000, 1);

        // Global stall mid-stream.
        step(1, 16'h8F81, 1);
        step(1, 16'h9A02, 0);
        I_enable = 1'b0;
        step(1, 16'hE0FF, 1);
        step(1, 16'hE0FF, 1);
        I_enable = 1'b1;
        step(1, 16'hA7C3, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);

        // Reset with SKID full.
        step(1, 16'hC123, 0);
        step(1, 16'hD456, 0);
        I_reset = 1'b1;
        I_valid = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(O_ready), 0);
        @(negedge I_clk);
        #1;
        check_zero();
        q.delete();
        I_reset = 1'b0;
        step(0, 16'h0000, 1);

        // Full rate: one word per cycle, no bubbles.
        for (int i = 0; i < 100; i++) step(1, 16'($urandom()), 1);

        // Random handshakes over 1000 accepted words.
        acc_cnt = 0;
        for (int c = 0; c < 20000 && acc_cnt < 1000; c++) begin
            bit v, r;
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 3) != 0;
            if (v && q.size() < 2) acc_cnt++;
            step(v, 16'($urandom()), r);
        end
        chk("random_words", 32'(acc_cnt), 1000);
        for (int c = 0; c < 4; c++) step(0, 16'h0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, flow-controlled instruction decoder for the CPU front end. It sits between the fetch stage and the register file / ALU issue stage. Each accepted instruction word is split into opcode, register selects, flag bit and immediate. The immediate is extended to datapath width, and per-opcode control flags are added. A one-deep skid buffer holds back-pressure so that the upstream ready never depends combinationally on the downstream ready.

## Interface
Parameters:
- `OPCODE_WIDTH`, default 4: opcode field width.
- `REG_SEL_WIDTH`, default 3: width of each register select.
- `IMM_WIDTH`, default 8: raw immediate field width. Must satisfy `IMM_WIDTH >= 2*REG_SEL_WIDTH`.
- `INSTR_WIDTH`, default 16: instruction width. Must equal `OPCODE_WIDTH + REG_SEL_WIDTH + 1 + IMM_WIDTH`.
- `DATA_WIDTH`, default 16: width of the extended immediate. Must satisfy `DATA_WIDTH >= IMM_WIDTH`.
- `SIGNED_IMM_MASK`, default 16'h0000: bit n = 1 means opcode n sign-extends its immediate.
- `WRITES_RD_MASK`, default 16'hFFFF: bit n = 1 means opcode n writes rD.

Ports (clock and reset first):
- `I_clk` in 1: single clock. All state is updated on the rising edge.
- `I_reset` in 1: reset is synchronous and active-high.
- `I_enable` in 1: global stall. While 0, all state is frozen and `O_ready` = 0.
- `I_flush` in 1: discards every in-flight instruction.
- `I_valid` in 1: `I_instruction` is valid.
- `O_ready` out 1: decoder can accept an instruction.
- `I_instruction` in `INSTR_WIDTH`: instruction word.
- `O_valid` out 1: decoded outputs are valid.
- `I_ready` in 1: downstream accepts the decoded outputs.
- `O_opcode` out `OPCODE_WIDTH`: opcode field.
- `O_rD_select`, `O_rA_select`, `O_rB_select` out `REG_SEL_WIDTH`: register selects.
- `O_flag` out 1: the single bit between the rD and rA fields.
- `O_immediate` out `DATA_WIDTH`: extended immediate.
- `O_writes_rd` out 1: `WRITES_RD_MASK[opcode]`.

## Operation
- Field layout is fixed, MSB first:
  - opcode: `[INSTR_WIDTH-1 -: OPCODE_WIDTH]`
  - rD: next `REG_SEL_WIDTH` bits
  - flag: next 1 bit
  - immediate: `[IMM_WIDTH-1:0]`
- rA = `[IMM_WIDTH-1 -: REG_SEL_WIDTH]`. rB is the `REG_SEL_WIDTH` bits directly below rA. rA and rB overlap the immediate; this is intentional.
- Immediate extension: sign-extend if `SIGNED_IMM_MASK[opcode]`, else zero-extend. Mask bits at index ≥ 2^`OPCODE_WIDTH` are ignored.
- Accept = `I_valid & O_ready`. Emit = `O_valid & I_ready`.
- Internal state:
  - output register (OUT): valid bit plus decoded record.
  - skid register (SKID): valid bit plus decoded record.
- `O_ready` = `I_enable & ~SKID.valid & ~I_reset` (combinational from registered state).
- Per-cycle update, only when `I_enable` = 1:
  - OUT empty or emitting, SKID empty: an accepted input loads OUT. With no accept, OUT.valid clears.
  - OUT empty or emitting, SKID full: SKID moves into OUT and SKID clears. No accept is possible this cycle.
  - OUT full and stalled: an accepted input loads SKID. OUT holds.
- Decoded outputs are held stable while `O_valid & ~I_ready`.
- `I_flush` = 1 (with `I_enable` = 1): OUT.valid and SKID.valid clear on this edge. An input presented in the same cycle is dropped, even though `O_ready` was 1.
- `I_flush` overrides accept and emit.

## Timing
- Latency: an instruction accepted at edge N gives `O_valid` = 1 after edge N. That is one cycle, with no bubble when `I_ready` is held at 1.
- Throughput: one instruction per cycle.
- Reset, while `I_reset` = 1 at an edge:
  - `O_valid` = 0, SKID empty.
  - `O_opcode`, selects, `O_flag`, `O_immediate`, `O_writes_rd` all = 0.
  - Reset wins over `I_enable` and `I_flush`. Reset mid-stream drops both entries.
- First accept is possible in the cycle after `I_reset` falls.
- `I_enable` = 0: no state change, `O_valid` and data held, `O_ready` = 0. Downstream must not count a handshake while `I_enable` is low.
- Ordering is preserved across skid use. No instruction is duplicated or lost, except on flush or reset.

## Structure
- Package `decoder_pkg`:
  - default width localparams
  - field-offset functions
  - `decoded_t` struct (opcode, rD, rA, rB, flag, imm, writes_rd)
- Sub-module `decoder_fields`: combinational extraction plus extension from instruction to `decoded_t`. It is instantiated once on the input side. OUT and SKID store `decoded_t`.

## Test plan
- Defaults, `SIGNED_IMM_MASK` = 16'h0004, `I_ready` = 1. Input 16'h1A3C → next cycle: opcode 1, rD 5, flag 0, rA 1, rB 7, imm 16'h003C, writes_rd 1.
- Same configuration, input 16'h25F0 → opcode 2, rD 2, flag 1, rA 7, rB 4, imm 16'hFFF0. Repeat with mask 0 → imm 16'h00F0.
- Back-to-back 16'h1A3C, 16'h25F0, with `I_ready` = 0 for 3 cycles after the first output:
  - the second word is captured in SKID
  - `O_ready` = 0 while SKID is full
  - on release, both words emerge in order, outputs held stable throughout.
- `I_flush` with OUT and SKID both full, and a valid input in the same cycle → `O_valid` = 0 next cycle, nothing emerges, `O_ready` = 1.
- `I_enable` = 0 for 2 cycles mid-stream → outputs frozen, `O_ready` = 0, the stream resumes unchanged. Then `I_reset` pulsed with SKID full → all outputs 0, `O_valid` = 0.
- Random `I_valid`/`I_ready` over 1000 words against a scoreboard → in-order, lossless, one per cycle at full rate.
